// File: rtl/pixel_pkg.sv
//==============================================================================
// Module   : pixel_pkg
// Brief    : Shared defaults, write-FSM encoding and RGB888->RGB565 conversion.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package pixel_pkg;

   localparam int unsigned c_def_width  = 160;
   localparam int unsigned c_def_height = 120;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } wr_state_t;

   // One buffered pixel; y/x kept raw so the address multiply happens after the FIFO.
   typedef struct packed {
      logic [7:0]  y;
      logic [7:0]  x;
      logic [23:0] color;
   } pixel_t;

   localparam int unsigned c_pix_w = $bits(pixel_t);

   function automatic logic [15:0] rgb888_to_565(input logic [23:0] c);
      return {c[23:19], c[15:10], c[7:3]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_writer_if.sv
//==============================================================================
// Module   : pixel_writer_if
// Brief    : Framebuffer write bus (request/ack handshake with address and data).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pixel_writer_if #(
   parameter int unsigned ADDR_W = 15
);

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_ack;

   modport master (
      output mem_req,
      output mem_addr,
      output mem_wdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack
   );

endinterface

`default_nettype wire

// File: rtl/pixel_fifo.sv
//==============================================================================
// Module   : pixel_fifo
// Brief    : Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pixel_fifo #(
   parameter int unsigned DATA_W = 40,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0]      r_mem [DEPTH];
   logic [c_ptr_w-1:0]     r_wr_ptr;
   logic [c_ptr_w-1:0]     r_rd_ptr;
   logic [$clog2(DEPTH):0] r_count;

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign rdata = r_mem[r_rd_ptr];
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pixel_writer.sv
//==============================================================================
// Module   : pixel_writer
// Brief    : Clips, buffers and converts pixels, then writes them to a framebuffer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pixel_writer
   import pixel_pkg::*;
#(
   parameter int unsigned WIDTH      = c_def_width,
   parameter int unsigned HEIGHT     = c_def_height,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [7:0]    in_x,
   input  logic [7:0]    in_y,
   input  logic [23:0]   in_color,
   input  logic          in_done,
   input  logic          clr_stat,
   pixel_writer_if.master mem,
   output logic          busy,
   output logic          frame_done,
   output logic          overflow,
   output logic [15:0]   clip_cnt
);

   localparam int unsigned        c_cnt_w  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(FIFO_DEPTH);
   localparam logic [8:0]         c_x_lim  = 9'((WIDTH  > 256) ? 256 : WIDTH);
   localparam logic [8:0]         c_y_lim  = 9'((HEIGHT > 256) ? 256 : HEIGHT);
   localparam logic [ADDR_W-1:0]  c_stride = ADDR_W'(WIDTH);

   wr_state_t          r_state;
   wr_state_t          w_state_nxt;
   pixel_t             w_push_pix;
   pixel_t             w_head;
   logic               w_inb;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic               w_clip;
   logic               w_empty;
   logic [c_cnt_w-1:0] w_count;
   logic               w_frame;
   logic               r_req;
   logic               w_req_nxt;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W-1:0]  w_addr_nxt;
   logic [15:0]        r_wdata;
   logic [15:0]        w_wdata_nxt;
   logic               r_done_pend;
   logic               r_frame_done;
   logic               r_overflow;
   logic [15:0]        r_clip_cnt;
   logic [15:0]        w_clip_base;

   // Admission uses the count seen at this edge, so a same-edge pop never saves a pixel.
   assign w_inb      = ({1'b0, in_x} < c_x_lim) && ({1'b0, in_y} < c_y_lim);
   assign w_push     = in_valid && w_inb && (w_count < c_depth);
   assign w_drop     = in_valid && w_inb && (w_count >= c_depth);
   assign w_clip     = in_valid && !w_inb;
   assign w_push_pix = {in_y, in_x, in_color};

   pixel_fifo #(
      .DATA_W (c_pix_w),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .wdata (w_push_pix),
      .pop   (w_pop),
      .rdata (w_head),
      .empty (w_empty),
      .count (w_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_req_nxt   = r_req;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_req_nxt   = 1'b1;
               w_addr_nxt  = ADDR_W'(w_head.y) * c_stride + ADDR_W'(w_head.x);
               w_wdata_nxt = rgb888_to_565(w_head.color);
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem.mem_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
      end
   end

   assign w_frame = r_done_pend && w_empty && (r_state == ST_IDLE);

   // A new in_done arriving on the completion edge re-arms the flag for the next primitive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_pend  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame;
         if (in_done) begin
            r_done_pend <= 1'b1;
         end else if (w_frame) begin
            r_done_pend <= 1'b0;
         end
      end
   end

   assign w_clip_base = clr_stat ? 16'd0 : r_clip_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
         r_clip_cnt <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_stat) begin
            r_overflow <= 1'b0;
         end
         if (w_clip) begin
            r_clip_cnt <= (w_clip_base == 16'hFFFF) ? w_clip_base : w_clip_base + 16'd1;
         end else if (clr_stat) begin
            r_clip_cnt <= '0;
         end
      end
   end

   assign mem.mem_req   = r_req;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;

   assign busy       = !w_empty || (r_state == ST_REQ) || r_done_pend;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign clip_cnt   = r_clip_cnt;

endmodule

`default_nettype wire
